// File: rtl/node_id_pkg.sv
// node_id_pkg: shared types, constants and the ASCII name encoder for the
// node index allocator. The typedefs reflect the default widths; the
// parameterized modules size their own vectors from their parameters.
package node_id_pkg;

  localparam int DEF_NODE_CHARS     = 3;
  localparam int DEF_CHAR_BITS      = 5;
  localparam int DEF_NODE_STR_WIDTH = DEF_NODE_CHARS * DEF_CHAR_BITS;
  localparam int DEF_MAX_NODES      = 1024;
  localparam int DEF_NODE_IDX_WIDTH = $clog2(DEF_MAX_NODES);

  // Characters are stored as an offset from 'a'.
  localparam logic [7:0] A_CHAR = 8'h61;

  typedef logic [DEF_NODE_STR_WIDTH-1:0] node_str_t;
  typedef logic [DEF_NODE_IDX_WIDTH-1:0] node_idx_t;

  typedef enum logic [2:0] {
    IDLE,
    RES_SRC,
    RES_DST,
    EMIT,
    DONE
  } state_t;

  // Packs an ASCII name (first character in the most significant byte, as
  // a string literal lays it out) into the node encoding: char 0 at the
  // LSBs, each char as (ascii - 'a') truncated to cbits. Names up to 8 chars.
  function automatic logic [63:0] encode_name(input logic [63:0] ascii,
                                              input int nchars,
                                              input int cbits);
    logic [63:0] r;
    logic [7:0]  c;
    r = '0;
    for (int i = 0; i < nchars; i++) begin
      c = ascii[(nchars-1-i)*8 +: 8];
      r = r | ((64'(c - A_CHAR) & ((64'd1 << cbits) - 64'd1)) << (i*cbits));
    end
    return r;
  endfunction

endpackage

// File: rtl/node_index_lut.sv
// node_index_lut: direct-mapped name -> index store.
//   addr   : encoded node name (one entry per possible name)
//   we     : allocate this name with index wdata
//   hit    : name already has an index
//   rdata  : stored index (only meaningful when hit)
// The assigned bitmap is reset; the index RAM is not, since an entry is only
// ever read through a set assigned bit. Reads are combinational so a write
// in one cycle is visible to the next cycle's lookup.
module node_index_lut
  import node_id_pkg::*;
#(
  parameter int STR_W = DEF_NODE_STR_WIDTH,
  parameter int IDX_W = DEF_NODE_IDX_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [STR_W-1:0] addr,
  input  logic             we,
  input  logic [IDX_W-1:0] wdata,
  output logic             hit,
  output logic [IDX_W-1:0] rdata
);

  localparam int DEPTH = 2**STR_W;

  logic [DEPTH-1:0] assigned;
  logic [IDX_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  assigned       <= '0;
    else if (we) assigned[addr] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign hit   = assigned[addr];
  assign rdata = mem[addr];

endmodule

// File: rtl/node_id_allocator.sv
// node_id_allocator: assigns dense indices to node names in order of first
// appearance. Each input beat carries a source name and optionally a
// destination name; the beat is emitted with both names replaced by indices.
//   in_*      : valid/ready beat with src/dst names, has_dst, last
//   out_*     : valid/ready beat with src/dst indices, has_dst, last
//   node_cnt  : number of indices handed out
//   overflow  : sticky, a new name arrived with the index space full
//   tag_idx   : index of each tagged name, tag k at [k*W +: W]
//   tag_seen  : tagged name k has been resolved at least once
//   tags_all_seen, done : all tags seen / last beat handed off (sticky)
module node_id_allocator
  import node_id_pkg::*;
#(
  parameter int NODE_CHARS     = 3,
  parameter int CHAR_BITS      = 5,
  parameter int NODE_STR_WIDTH = NODE_CHARS * CHAR_BITS,
  parameter int MAX_NODES      = 1024,
  parameter int NODE_IDX_WIDTH = $clog2(MAX_NODES),
  parameter int NUM_TAGS       = 4,
  parameter logic [8*NODE_CHARS-1:0] TAG_NAMES [NUM_TAGS] = '{"svr", "dac", "fft", "out"}
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [NODE_STR_WIDTH-1:0]          in_src_str,
  input  logic [NODE_STR_WIDTH-1:0]          in_dst_str,
  input  logic                               in_has_dst,
  input  logic                               in_last,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [NODE_IDX_WIDTH-1:0]          out_src_idx,
  output logic [NODE_IDX_WIDTH-1:0]          out_dst_idx,
  output logic                               out_has_dst,
  output logic                               out_last,
  output logic [NODE_IDX_WIDTH:0]            node_cnt,
  output logic                               overflow,
  output logic [NUM_TAGS*NODE_IDX_WIDTH-1:0] tag_idx,
  output logic [NUM_TAGS-1:0]                tag_seen,
  output logic                               tags_all_seen,
  output logic                               done
);

  state_t state, state_nx;

  logic [NODE_STR_WIDTH-1:0] cap_src, cap_dst;
  logic [NODE_STR_WIDTH-1:0] cur_str;
  logic [NODE_IDX_WIDTH-1:0] lut_rdata, res_idx;
  logic                      lut_hit, resolving, full, alloc, ovf_evt, accept;
  logic [NUM_TAGS-1:0]       tag_match;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == EMIT);
  assign accept    = in_ready && in_valid;
  assign resolving = (state == RES_SRC) || (state == RES_DST);
  assign cur_str   = (state == RES_DST) ? cap_dst : cap_src;
  assign full      = (node_cnt == (NODE_IDX_WIDTH+1)'(MAX_NODES));

  // A name seen for the first time takes node_cnt; once full it gets 0 and
  // stays unassigned so it would resolve again if space ever appeared.
  assign alloc   = resolving && !lut_hit && !full;
  assign ovf_evt = resolving && !lut_hit && full;
  assign res_idx = lut_hit ? lut_rdata
                 : full    ? '0
                 :           node_cnt[NODE_IDX_WIDTH-1:0];

  node_index_lut #(
    .STR_W (NODE_STR_WIDTH),
    .IDX_W (NODE_IDX_WIDTH)
  ) u_lut (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (cur_str),
    .we    (alloc),
    .wdata (node_cnt[NODE_IDX_WIDTH-1:0]),
    .hit   (lut_hit),
    .rdata (lut_rdata)
  );

  for (genvar k = 0; k < NUM_TAGS; k++) begin : g_tag
    localparam logic [NODE_STR_WIDTH-1:0] TAG_ENC =
      NODE_STR_WIDTH'(encode_name(64'(TAG_NAMES[k]), NODE_CHARS, CHAR_BITS));
    assign tag_match[k] = (cur_str == TAG_ENC);
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid) state_nx = RES_SRC;
      RES_SRC: state_nx = out_has_dst ? RES_DST : EMIT;
      RES_DST: state_nx = EMIT;
      EMIT:    if (out_ready) state_nx = out_last ? DONE : IDLE;
      DONE:    state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cap_src       <= '0;
      cap_dst       <= '0;
      out_has_dst   <= 1'b0;
      out_last      <= 1'b0;
      out_src_idx   <= '0;
      out_dst_idx   <= '0;
      node_cnt      <= '0;
      overflow      <= 1'b0;
      tag_seen      <= '0;
      tag_idx       <= '0;
      tags_all_seen <= 1'b0;
      done          <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cap_src     <= in_src_str;
        cap_dst     <= in_dst_str;
        out_has_dst <= in_has_dst;
        out_last    <= in_last;
      end
      if (state == RES_SRC) begin
        out_src_idx <= res_idx;
        out_dst_idx <= '0;
      end
      if (state == RES_DST) out_dst_idx <= res_idx;
      if (alloc)   node_cnt <= node_cnt + 1'b1;
      if (ovf_evt) overflow <= 1'b1;
      for (int k = 0; k < NUM_TAGS; k++) begin
        if (resolving && tag_match[k] && !tag_seen[k]) begin
          tag_seen[k]                                  <= 1'b1;
          tag_idx[k*NODE_IDX_WIDTH +: NODE_IDX_WIDTH] <= res_idx;
        end
      end
      tags_all_seen <= &tag_seen;
      if ((state == EMIT) && out_ready && out_last) done <= 1'b1;
    end
  end

endmodule
